// File: rtl/seg_pkg.sv
// Shared types and glyph decode for the seven-segment scan path.
package seg_pkg;
    localparam int SEG_W = 7;

    // Segment vector {a,b,c,d,e,f,g}: bit 6 = a, bit 0 = g, active-high form.
    typedef logic [SEG_W-1:0] seg_t;

    function automatic seg_t glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    glyph = 7'b1111110;
            4'h1:    glyph = 7'b0110000;
            4'h2:    glyph = 7'b1101101;
            4'h3:    glyph = 7'b1111001;
            4'h4:    glyph = 7'b0110011;
            4'h5:    glyph = 7'b1011011;
            4'h6:    glyph = 7'b1011111;
            4'h7:    glyph = 7'b1110000;
            4'h8:    glyph = 7'b1111111;
            4'h9:    glyph = 7'b1111011;
            4'hA:    glyph = 7'b1110111;
            4'hB:    glyph = 7'b0011111;
            4'hC:    glyph = 7'b1001110;
            4'hD:    glyph = 7'b0111101;
            4'hE:    glyph = 7'b1001111;
            default: glyph = 7'b1000111;
        endcase
    endfunction
endpackage

// File: rtl/seg_scan_timer.sv
// Slot prescaler, digit index, frame counter and blink phase for the scan controller.
// frame_start is combinational from the counter state; no backpressure.
module seg_scan_timer #(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64,
    parameter int PCNT_W    = $clog2(SCAN_DIV),
    parameter int IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [PCNT_W-1:0] pcnt,
    output logic [IDX_W-1:0]  idx,
    output logic              frame_start,
    output logic              blink_phase
);
    localparam int FCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(DIGITS - 1);
    localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(BLINK_DIV - 1);

    logic [FCNT_W-1:0] fcnt;

    assign frame_start = (pcnt == '0) && (idx == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt        <= '0;
            idx         <= '0;
            fcnt        <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (pcnt == PCNT_MAX) begin
                pcnt <= '0;
                idx  <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
            if (frame_start) begin
                if (fcnt == FCNT_MAX) begin
                    fcnt        <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with per-frame shadowed inputs.
// All outputs registered, 1-cycle latency from counter/shadow state; no backpressure.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 64,
    parameter int PWM_BITS   = 3,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   display_data,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  lz_blank,
    input  logic [PWM_BITS-1:0]   brightness,
    output logic [DIGITS-1:0]     an,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp,
    output logic                  frame_tick
);
    localparam int   PCNT_W = $clog2(SCAN_DIV);
    localparam int   IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic INV    = (ACTIVE_LOW != 0);

    logic [PCNT_W-1:0] pcnt;
    logic [IDX_W-1:0]  idx;
    logic              frame_start;
    logic              blink_phase;

    seg_scan_timer #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV),
        .PCNT_W    (PCNT_W),
        .IDX_W     (IDX_W)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .pcnt        (pcnt),
        .idx         (idx),
        .frame_start (frame_start),
        .blink_phase (blink_phase)
    );

    logic [4*DIGITS-1:0] sh_data;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_blank;
    logic [DIGITS-1:0]   sh_blink;
    logic                sh_lz;
    logic [PWM_BITS-1:0] sh_bright;
    logic                sh_phase;

    // Blink phase is shadowed with the rest so a whole frame is shown or hidden as a unit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_data   <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            sh_blink  <= '0;
            sh_lz     <= 1'b0;
            sh_bright <= '0;
            sh_phase  <= 1'b0;
        end else if (frame_start) begin
            sh_data   <= display_data;
            sh_dp     <= dp_mask;
            sh_blank  <= blank_mask;
            sh_blink  <= blink_mask;
            sh_lz     <= lz_blank;
            sh_bright <= brightness;
            sh_phase  <= blink_phase;
        end
    end

    logic [DIGITS-1:0] lead_zero;
    logic [DIGITS-1:0] onehot;
    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic              cur_blank;
    logic              cur_blink;
    logic              cur_lead;
    logic              lit;

    always_comb begin
        logic run;
        run       = 1'b1;
        lead_zero = '0;
        onehot    = '0;
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_blink = 1'b0;
        cur_lead  = 1'b0;
        // lead_zero[i]: every nibble from the top digit down to i is zero
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run          = run && (sh_data[4*i +: 4] == 4'h0);
            lead_zero[i] = run;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                onehot[i] = 1'b1;
                cur_nib   = sh_data[4*i +: 4];
                cur_dp    = sh_dp[i];
                cur_blank = sh_blank[i];
                cur_blink = sh_blink[i];
                cur_lead  = lead_zero[i];
            end
        end
        lit = !cur_blank
           && !(cur_blink && sh_phase)
           && !(sh_lz && (idx != '0) && cur_lead)
           && (pcnt[PWM_BITS-1:0] <= sh_bright);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an         <= {DIGITS{INV}};
            seg        <= {SEG_W{INV}};
            dp         <= INV;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_start;
            if (lit) begin
                an  <= onehot ^ {DIGITS{INV}};
                seg <= glyph(cur_nib) ^ {SEG_W{INV}};
                dp  <= cur_dp ^ INV;
            end else begin
                an  <= {DIGITS{INV}};
                seg <= {SEG_W{INV}};
                dp  <= INV;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a frame/slot arithmetic reference model.
module tb_seg_scan_ctrl;
    localparam int D  = 4;
    localparam int SD = 8;
    localparam int BD = 2;
    localparam int PB = 3;
    localparam int FRAME = D * SD;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4*D-1:0] display_data;
    logic [D-1:0]  dp_mask, blank_mask, blink_mask;
    logic          lz_blank;
    logic [PB-1:0] brightness;
    logic [D-1:0]  an;
    logic [6:0]    seg;
    logic          dp;
    logic          frame_tick;

    int n_tests = 0;
    int n_fail  = 0;

    seg_scan_ctrl #(
        .DIGITS(D), .SCAN_DIV(SD), .BLINK_DIV(BD), .PWM_BITS(PB), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .display_data(display_data), .dp_mask(dp_mask),
        .blank_mask(blank_mask), .blink_mask(blink_mask), .lz_blank(lz_blank),
        .brightness(brightness), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Reference model: cycles since reset release plus the inputs captured at each frame start.
    int             t;
    logic [4*D-1:0] m_data;
    logic [D-1:0]   m_dp, m_blank, m_blink;
    logic           m_lz, m_ph;
    logic [PB-1:0]  m_br;
    logic [D-1:0]   exp_an;
    logic [6:0]     exp_seg;
    logic           exp_dp, exp_ft;

    task automatic tick();
        int pc, id, f;
        logic [3:0] nib;
        bit lit;
        if (!rst_n) begin
            t = 0; m_data = '0; m_dp = '0; m_blank = '0; m_blink = '0;
            m_lz = 0; m_ph = 0; m_br = '0;
            exp_an = '1; exp_seg = '1; exp_dp = 1'b1; exp_ft = 1'b0;
        end else begin
            pc  = t % SD;
            id  = (t / SD) % D;
            f   = t / FRAME;
            nib = 4'(m_data >> (4 * id));
            lit = !m_blank[id] && !(m_blink[id] && m_ph)
                && !(m_lz && id > 0 && (m_data >> (4 * id)) == 0)
                && ((pc % (1 << PB)) <= int'(m_br));
            exp_ft = (pc == 0 && id == 0);
            if (lit) begin
                exp_an  = ~(4'b0001 << id);
                exp_seg = ~glyph_tab[nib];
                exp_dp  = ~m_dp[id];
            end else begin
                exp_an = '1; exp_seg = '1; exp_dp = 1'b1;
            end
            if (pc == 0 && id == 0) begin
                m_data = display_data; m_dp = dp_mask; m_blank = blank_mask;
                m_blink = blink_mask; m_lz = lz_blank; m_br = brightness;
                m_ph = ((f / BD) % 2) == 1;
            end
            t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        display_data = 16'h1234; dp_mask = '0; blank_mask = '0; blink_mask = '0;
        lz_blank = 0; brightness = 3'd7;
        do_reset();
        n_tests++;
        if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs got an=%b seg=%b dp=%b ft=%b want 1111 1111111 1 0",
                     an, seg, dp, frame_tick);
        end
    endtask

    task automatic test_scan();
        int last_ft = -1;
        for (int c = 0; c < 3 * FRAME; c++) begin
            tick();
            n_tests++;
            if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
                n_fail++;
                $display("FAIL scan t=%0d got %b/%b/%b/%b want %b/%b/%b/%b", t, an, seg, dp,
                         frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
            end
            if (frame_tick === 1'b1) begin
                if (last_ft >= 0) begin
                    n_tests++;
                    if (c - last_ft != FRAME) begin
                        n_fail++;
                        $display("FAIL frame_period got %0d want %0d", c - last_ft, FRAME);
                    end
                end
                last_ft = c;
            end
        end
    endtask

    task automatic test_midframe_update();
        repeat (FRAME / 2 + 3) tick();
        display_data = 16'hABCD;
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            n_tests++;
            if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
                n_fail++;
                $display("FAIL midframe t=%0d got %b/%b/%b want %b/%b/%b", t, an, seg, dp,
                         exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    task automatic test_lz_blank();
        logic [15:0] pats [2] = '{16'h0005, 16'h0000};
        int upper_on;
        lz_blank = 1'b1;
        for (int p = 0; p < 2; p++) begin
            display_data = pats[p];
            repeat (FRAME) tick();
            upper_on = 0;
            for (int c = 0; c < FRAME; c++) begin
                tick();
                if (an[3:1] !== 3'b111) upper_on++;
                n_tests++;
                if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                    n_fail++;
                    $display("FAIL lz t=%0d got %b/%b want %b/%b", t, an, seg, exp_an, exp_seg);
                end
            end
            n_tests++;
            if (upper_on != 0) begin
                n_fail++;
                $display("FAIL lz_upper_dark pat=%h got %0d lit cycles want 0", pats[p], upper_on);
            end
        end
        lz_blank = 1'b0;
        display_data = 16'h1234;
    endtask

    task automatic test_pwm();
        int on_cnt;
        for (int b = 1; b >= 0; b--) begin
            brightness = 3'(b);
            repeat (FRAME) tick();
            on_cnt = 0;
            for (int c = 0; c < FRAME; c++) begin
                tick();
                if (an !== 4'hF) on_cnt++;
                n_tests++;
                if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                    n_fail++;
                    $display("FAIL pwm t=%0d got %b want %b", t, an, exp_an);
                end
            end
            n_tests++;
            if (on_cnt != D * (SD / 8) * (b + 1)) begin
                n_fail++;
                $display("FAIL pwm_duty br=%0d got %0d want %0d", b, on_cnt, D * (SD / 8) * (b + 1));
            end
        end
        brightness = 3'd7;
    endtask

    task automatic test_blink_dp();
        int d0_on [6];
        blink_mask = 4'b0001;
        dp_mask    = 4'b0010;
        do_reset();
        for (int f = 0; f < 6; f++) begin
            d0_on[f] = 0;
            for (int c = 0; c < FRAME; c++) begin
                tick();
                if (an[0] === 1'b0) d0_on[f]++;
                n_tests++;
                if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                    n_fail++;
                    $display("FAIL blink t=%0d got %b/%b want %b/%b", t, an, dp, exp_an, exp_dp);
                end
            end
        end
        n_tests++;
        if (d0_on[1] != SD || d0_on[3] != 0 || d0_on[5] != SD) begin
            n_fail++;
            $display("FAIL blink_frames got f1=%0d f3=%0d f5=%0d want %0d 0 %0d",
                     d0_on[1], d0_on[3], d0_on[5], SD, SD);
        end
        blink_mask = '0;
        dp_mask    = '0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 8 * FRAME; c++) begin
            if ($urandom_range(0, 9) == 0) display_data = 16'($urandom);
            if ($urandom_range(0, 15) == 0) dp_mask = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blank_mask = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
            if ($urandom_range(0, 15) == 0) lz_blank = 1'($urandom);
            if ($urandom_range(0, 15) == 0) brightness = 3'($urandom);
            tick();
            n_tests++;
            if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}
                || $countones(~an) > 1) begin
                n_fail++;
                $display("FAIL random t=%0d got %b/%b/%b/%b want %b/%b/%b/%b", t, an, seg, dp,
                         frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
            end
        end
    endtask

    task automatic test_reset_midslot();
        display_data = 16'h1234; dp_mask = '0; blank_mask = '0; blink_mask = '0;
        lz_blank = 0; brightness = 3'd7;
        repeat (2 * FRAME - (t % FRAME) + 2 * SD + 3) tick();
        rst_n = 1'b0;
        tick();
        n_tests++;
        if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_midslot got an=%b seg=%b dp=%b want 1111 1111111 1", an, seg, dp);
        end
        rst_n = 1'b1;
        for (int c = 0; c < FRAME + 2; c++) begin
            tick();
            n_tests++;
            if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
                n_fail++;
                $display("FAIL restart t=%0d got %b/%b/%b want %b/%b/%b", t, an, seg,
                         frame_tick, exp_an, exp_seg, exp_ft);
            end
        end
        n_tests++;
        if (t != FRAME + 2 || an !== 4'b1110) begin
            n_fail++;
            $display("FAIL restart_digit0 got an=%b want 1110", an);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        display_data = '0; dp_mask = '0; blank_mask = '0; blink_mask = '0;
        lz_blank = 0; brightness = '0;
        test_reset();
        test_scan();
        test_midframe_update();
        test_lz_blank();
        test_pwm();
        test_blink_dp();
        test_random();
        test_reset_midslot();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
